// File: rtl/lcd_i2c_ctrl_if.sv
// lcd_i2c_ctrl_if: Avalon-MM slave bus bundle for the LCD I2C controller.
// The master modport drives the bus and the slave modport answers reads.
interface lcd_i2c_ctrl_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_i2c_ctrl.sv
// lcd_i2c_ctrl: Avalon-MM I2C master for PCF8574-style LCD backpacks.
// One TXDATA write runs START, addr+W, data byte, STOP on open-drain lines.
module lcd_i2c_ctrl #(
    parameter int         CLK_DIV      = 125,
    parameter logic [6:0] DEFAULT_ADDR = 7'h27
) (
    input  logic          clk,
    input  logic          reset,
    lcd_i2c_ctrl_if.slave bus,
    input  logic          en,
    input  logic          sda_in,
    output logic          scl_oe,
    output logic          sda_oe,
    output logic          irq
);
    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_ACK1  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_ACK2  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    logic [2:0]    state;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic [7:0]    txdata;
    logic [7:0]    ctrl;
    logic          done, nack, ovr, abt;
    logic [1:0]    sda_sync;
    logic          en_q, abort_req, ack_bad;

    logic busy, wr, wr_tx, wr_ctrl, wr_stat, tx_acc;
    logic tick, slot_end, stop_req;
    logic nack_set, done_set, abt_set, in_ack;

    assign busy     = (state != S_IDLE);
    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_tx    = wr & (bus.address == 2'd0);
    assign wr_ctrl  = wr & (bus.address == 2'd1);
    assign wr_stat  = wr & (bus.address == 2'd2);
    assign tx_acc   = wr_tx & ~busy & en;
    assign tick     = busy & (qcnt == QMAX);
    assign slot_end = tick & (q == 2'd3);
    assign stop_req = abort_req | ~en;
    assign in_ack   = (state == S_ACK1) | (state == S_ACK2);
    assign nack_set = tick & (q == 2'd2) & in_ack & sda_sync[1];
    assign done_set = slot_end & (state == S_STOP);
    assign abt_set  = busy & en_q & ~en;
    assign irq      = done & ctrl[7];

    // Pad synchroniser and enable edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_sync <= 2'b11;
            en_q     <= 1'b0;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
            en_q     <= en;
        end
    end

    // Quarter timing, bit sequencing and the transaction FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            qcnt    <= '0;
            q       <= 2'd0;
            bitn    <= 3'd0;
            sh      <= 8'h00;
            ack_bad <= 1'b0;
        end else if (!busy) begin
            qcnt <= '0;
            q    <= 2'd0;
            bitn <= 3'd0;
            if (tx_acc) begin
                state <= S_START;
                sh    <= {ctrl[6:0], 1'b0};
            end
        end else begin
            qcnt <= tick ? '0 : qcnt + QW'(1);
            if (tick) begin
                q <= q + 2'd1;
                if (q == 2'd2) begin
                    ack_bad <= sda_sync[1];
                end
            end
            if (slot_end) begin
                unique case (state)
                    S_START: state <= S_ADDR;
                    S_ADDR: begin
                        sh   <= {sh[6:0], 1'b0};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) state <= S_ACK1;
                    end
                    S_ACK1: begin
                        sh    <= txdata;
                        state <= ack_bad ? S_STOP : S_DATA;
                    end
                    S_DATA: begin
                        sh   <= {sh[6:0], 1'b0};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) state <= S_ACK2;
                    end
                    S_ACK2:  state <= S_STOP;
                    S_STOP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
                if (stop_req && state != S_STOP) begin
                    state <= S_STOP;
                end
            end
        end
    end

    // Abort request latched until the current transaction completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_req <= 1'b0;
        end else begin
            abort_req <= busy & (abort_req | abt_set) & ~done_set;
        end
    end

    // Software registers: TXDATA, CTRL and sticky W1C status bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txdata <= 8'h00;
            ctrl   <= {1'b0, DEFAULT_ADDR};
            done   <= 1'b0;
            nack   <= 1'b0;
            ovr    <= 1'b0;
            abt    <= 1'b0;
        end else begin
            if (tx_acc)  txdata <= bus.writedata;
            if (wr_ctrl) ctrl   <= bus.writedata;
            done <= done_set | (done & ~(wr_stat & bus.writedata[1]));
            nack <= nack_set | (nack & ~(wr_stat & bus.writedata[2]));
            ovr  <= (wr_tx & ~tx_acc) | (ovr & ~(wr_stat & bus.writedata[3]));
            abt  <= abt_set | (abt & ~(wr_stat & bus.writedata[4]));
        end
    end

    // Line drive decoded from state and quarter
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state)
            S_START: begin
                sda_oe = q[1];
                scl_oe = (q == 2'd3);
            end
            S_ADDR, S_DATA: begin
                sda_oe = ~sh[7];
                scl_oe = ~q[1];
            end
            S_ACK1, S_ACK2: begin
                scl_oe = ~q[1];
            end
            S_STOP: begin
                sda_oe = ~q[1];
                scl_oe = (q == 2'd0);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // Zero-wait read mux
    always_comb begin
        bus.readdata = 8'h00;
        unique case (bus.address)
            2'd0:    bus.readdata = txdata;
            2'd1:    bus.readdata = ctrl;
            2'd2:    bus.readdata = {3'b000, abt, ovr, nack, done, busy};
            default: bus.readdata = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_lcd_i2c_ctrl.sv
// tb_lcd_i2c_ctrl: directed bench for lcd_i2c_ctrl with CLK_DIV=4.
// A small I2C slave model decodes SDA and answers ACK slots.
module tb_lcd_i2c_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    logic sda_in;
    logic scl_oe, sda_oe, irq;

    lcd_i2c_ctrl_if bus();

    lcd_i2c_ctrl #(.CLK_DIV(4), .DEFAULT_ADDR(7'h27)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .en     (en),
        .sda_in (sda_in),
        .scl_oe (scl_oe),
        .sda_oe (sda_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       pull = 1'b0;
    logic       ack_a = 1'b1;
    logic       ack_d = 1'b1;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       scl_now, sda_now;
    logic [7:0] rx_a = 8'h00;
    logic [7:0] rx_d = 8'h00;
    int         nb = 0;
    int         starts = 0;
    int         stops = 0;
    int         scl_edges = 0;

    assign sda_in = ~(sda_oe | pull);

    // Slave model: sample lines each negedge, decode START/STOP/bits, drive ACK
    always @(negedge clk) begin
        scl_now = ~scl_oe;
        sda_now = ~(sda_oe | pull);
        if (scl_prev && scl_now && sda_prev && !sda_now) begin
            nb = 0;
            starts++;
        end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
            stops++;
        end
        if (!scl_prev && scl_now) begin
            if (nb < 8) rx_a = {rx_a[6:0], sda_now};
            else if (nb >= 9 && nb < 17) rx_d = {rx_d[6:0], sda_now};
            nb++;
        end
        if (scl_prev != scl_now) scl_edges++;
        if (scl_prev && !scl_now) begin
            pull = (nb == 8 && ack_a) || (nb == 17 && ack_d);
        end
        scl_prev = scl_now;
        sda_prev = ~(sda_oe | pull);
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic wait_idle(input int drop_at, output int c);
        c = 0;
        bus.address = 2'd2;
        #1;
        while (bus.readdata[0] && c < 2000) begin
            c++;
            if (c == drop_at) en = 1'b0;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        tests++;
        if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_lines: got scl=%b sda=%b irq=%b want 0 0 0",
                     scl_oe, sda_oe, irq);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(2'd1, d);
        tests++;
        if (d !== 8'h27) begin
            fails++;
            $display("FAIL reset_ctrl: got %h want 27", d);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_status: got %h want 00", d);
        end
        rd(2'd0, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_txdata: got %h want 00", d);
        end
    endtask

    task automatic test_basic;
        logic [7:0] d;
        int c, s0, p0;
        s0 = starts;
        p0 = stops;
        wr(2'd0, 8'hA5);
        wait_idle(-1, c);
        tests++;
        if (c !== 320) begin
            fails++;
            $display("FAIL basic_busy_len: got %0d want 320", c);
        end
        tests++;
        if (rx_a !== 8'h4E || rx_d !== 8'hA5) begin
            fails++;
            $display("FAIL basic_bytes: got %h %h want 4e a5", rx_a, rx_d);
        end
        tests++;
        if (starts !== s0 + 1 || stops !== p0 + 1) begin
            fails++;
            $display("FAIL basic_start_stop: got %0d %0d want %0d %0d",
                     starts - s0, stops - p0, 1, 1);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h02 || irq !== 1'b0) begin
            fails++;
            $display("FAIL basic_status: got %h irq=%b want 02 irq=0", d, irq);
        end
        wr(2'd2, 8'h1E);
    endtask

    task automatic test_addr_nack;
        logic [7:0] d;
        int c;
        wr(2'd1, 8'hBF);
        rd(2'd1, d);
        tests++;
        if (d !== 8'hBF) begin
            fails++;
            $display("FAIL nack_ctrl: got %h want bf", d);
        end
        ack_a = 1'b0;
        @(negedge clk);
        wr(2'd0, 8'h11);
        wait_idle(-1, c);
        tests++;
        if (c !== 176) begin
            fails++;
            $display("FAIL nack_busy_len: got %0d want 176", c);
        end
        tests++;
        if (rx_a !== 8'h7E || nb !== 10) begin
            fails++;
            $display("FAIL nack_bus: got addr %h rises %0d want 7e 10", rx_a, nb);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h06 || irq !== 1'b1) begin
            fails++;
            $display("FAIL nack_status: got %h irq=%b want 06 irq=1", d, irq);
        end
        wr(2'd2, 8'h06);
        rd(2'd2, d);
        tests++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            fails++;
            $display("FAIL nack_clear: got %h irq=%b want 00 irq=0", d, irq);
        end
        ack_a = 1'b1;
        wr(2'd1, 8'h27);
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        int c;
        wr(2'd0, 8'h3C);
        repeat (9) @(negedge clk);
        wr(2'd0, 8'h99);
        wait_idle(-1, c);
        tests++;
        if (c >= 2000 || rx_d !== 8'h3C) begin
            fails++;
            $display("FAIL ovr_data: got %h cycles %0d want 3c", rx_d, c);
        end
        rd(2'd0, d);
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL ovr_txdata: got %h want 3c", d);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h0A) begin
            fails++;
            $display("FAIL ovr_status: got %h want 0a", d);
        end
        wr(2'd2, 8'h1E);
    endtask

    task automatic test_disabled;
        logic [7:0] d;
        int e0;
        en = 1'b0;
        @(negedge clk);
        e0 = scl_edges;
        wr(2'd0, 8'h55);
        repeat (20) @(negedge clk);
        tests++;
        if (scl_edges !== e0 || scl_oe !== 1'b0) begin
            fails++;
            $display("FAIL dis_scl: got %0d edges want 0", scl_edges - e0);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h08) begin
            fails++;
            $display("FAIL dis_status: got %h want 08", d);
        end
        rd(2'd0, d);
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL dis_txdata: got %h want 3c", d);
        end
        wr(2'd2, 8'h08);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [7:0] d;
        int c, p0;
        p0 = stops;
        wr(2'd0, 8'hF0);
        wait_idle(216, c);
        tests++;
        if (c !== 240) begin
            fails++;
            $display("FAIL abt_busy_len: got %0d want 240", c);
        end
        rd(2'd2, d);
        tests++;
        if (d !== 8'h12) begin
            fails++;
            $display("FAIL abt_status: got %h want 12", d);
        end
        tests++;
        if (stops !== p0 + 1 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
            fails++;
            $display("FAIL abt_stop: got stops %0d scl=%b sda=%b want 1 0 0",
                     stops - p0, scl_oe, sda_oe);
        end
        en = 1'b1;
        wr(2'd2, 8'h1E);
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int c;
        wr(2'd0, 8'h5A);
        repeat (9) @(negedge clk);
        wr(2'd0, 8'h77);
        repeat (185) @(negedge clk);
        rd(2'd2, d);
        tests++;
        if (scl_oe !== 1'b1 || sda_oe !== 1'b1 || d !== 8'h09) begin
            fails++;
            $display("FAIL rst_pre: got scl=%b sda=%b st=%h want 1 1 09",
                     scl_oe, sda_oe, d);
        end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || bus.readdata !== 8'h00) begin
            fails++;
            $display("FAIL rst_async: got scl=%b sda=%b st=%h want 0 0 00",
                     scl_oe, sda_oe, bus.readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr(2'd0, 8'hC3);
        wait_idle(-1, c);
        tests++;
        if (c !== 320 || rx_a !== 8'h4E || rx_d !== 8'hC3) begin
            fails++;
            $display("FAIL rst_after: got %0d %h %h want 320 4e c3", c, rx_a, rx_d);
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 8'h00;
        #2;
        test_reset();
        test_basic();
        test_addr_nack();
        test_overrun();
        test_disabled();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
